// File: rtl/timer_entry_if.sv
// rtl/timer_entry_if.sv - keypad, chain-status and load-control signals of the timer entry stage
interface timer_entry_if;
    logic       key_valid;
    logic [3:0] key;
    logic       tick;
    logic       done;
    logic       door_open;
    logic [3:0] data_s0;
    logic [3:0] data_s1;
    logic [3:0] data_m0;
    logic [3:0] data_m1;
    logic       loadn;
    logic       en;
    logic       running;
    logic       entry_err;

    modport master (
        output key_valid, key, tick, done, door_open,
        input  data_s0, data_s1, data_m0, data_m1, loadn, en, running, entry_err
    );

    modport slave (
        input  key_valid, key, tick, done, door_open,
        output data_s0, data_s1, data_m0, data_m1, loadn, en, running, entry_err
    );
endinterface

// File: rtl/timer_entry.sv
// rtl/timer_entry.sv - MM:SS keypad entry buffer and load/enable control for the timer counter chain
module timer_entry #(
    parameter logic [3:0] KEY_START  = 4'hA,
    parameter logic [3:0] KEY_CLEAR  = 4'hB,
    parameter logic [3:0] QUICK_SEC1 = 4'd3
) (
    input  logic          clk,
    input  logic          clr,
    timer_entry_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE} state_t;

    state_t     state;
    logic [3:0] s0, s1, m0, m1;
    logic [2:0] cnt;
    logic       loadn_r;
    logic       load_en_r;
    logic       run_r;
    logic       running_r;
    logic       err_r;

    logic is_digit, is_start, is_clear, entry_ok;

    assign is_digit = bus.key_valid && (bus.key <= 4'd9);
    assign is_start = bus.key_valid && (bus.key == KEY_START) && !bus.door_open;
    assign is_clear = bus.key_valid && (bus.key == KEY_CLEAR);
    // Seconds-tens must be a legal mod-6 digit and a zero load would never count.
    assign entry_ok = (s1 <= 4'd5) && ({m1, m0, s1, s0} != 16'h0000);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            {m1, m0, s1, s0} <= 16'h0000;
            cnt       <= 3'd0;
            loadn_r   <= 1'b1;
            load_en_r <= 1'b0;
            run_r     <= 1'b0;
            running_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            err_r     <= 1'b0;
            loadn_r   <= 1'b1;
            load_en_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_digit) begin
                        {m1, m0, s1, s0} <= {m0, s1, s0, bus.key};
                        cnt   <= 3'd1;
                        state <= ENTRY;
                    end else if (is_start) begin
                        {m1, m0, s1, s0} <= {4'd0, 4'd0, QUICK_SEC1, 4'd0};
                        state     <= LOAD;
                        loadn_r   <= 1'b0;
                        load_en_r <= 1'b1;
                        running_r <= 1'b1;
                    end
                end
                ENTRY: begin
                    if (is_digit) begin
                        if (cnt == 3'd4) begin
                            err_r <= 1'b1;
                        end else begin
                            {m1, m0, s1, s0} <= {m0, s1, s0, bus.key};
                            cnt <= cnt + 3'd1;
                        end
                    end else if (is_start) begin
                        if (entry_ok) begin
                            state     <= LOAD;
                            loadn_r   <= 1'b0;
                            load_en_r <= 1'b1;
                            running_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end else if (is_clear) begin
                        {m1, m0, s1, s0} <= 16'h0000;
                        cnt   <= 3'd0;
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    state     <= RUN;
                    run_r     <= 1'b1;
                    running_r <= 1'b1;
                end
                RUN: begin
                    // done outranks door/CLEAR so a finished run never lands in PAUSE.
                    if (bus.done) begin
                        {m1, m0, s1, s0} <= 16'h0000;
                        cnt       <= 3'd0;
                        state     <= IDLE;
                        run_r     <= 1'b0;
                        running_r <= 1'b0;
                    end else if (bus.door_open || is_clear) begin
                        state     <= PAUSE;
                        run_r     <= 1'b0;
                        running_r <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (is_start) begin
                        state     <= RUN;
                        run_r     <= 1'b1;
                        running_r <= 1'b1;
                    end else if (is_clear) begin
                        {m1, m0, s1, s0} <= 16'h0000;
                        cnt   <= 3'd0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    run_r     <= 1'b0;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    // done masks a coincident tick so the mod-6 stage never wraps past 00:00.
    assign bus.en        = load_en_r | (run_r & bus.tick & ~bus.done);
    assign bus.loadn     = loadn_r;
    assign bus.running   = running_r;
    assign bus.entry_err = err_r;
    assign bus.data_s0   = s0;
    assign bus.data_s1   = s1;
    assign bus.data_m0   = m0;
    assign bus.data_m1   = m1;

endmodule

// File: tb/tb_timer_entry.sv
// tb/tb_timer_entry.sv - directed vector table, clear-in-LOAD sequence and randomized model check of timer_entry
module tb_timer_entry;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    timer_entry_if bus();

    timer_entry #(
        .KEY_START (4'hA),
        .KEY_CLEAR (4'hB),
        .QUICK_SEC1(4'd3)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        kv;
        logic [3:0]  key;
        logic        tick;
        logic        done;
        logic        door;
        logic [15:0] bufe;
        logic        loadn_e;
        logic        en_e;
        logic        run_e;
        logic        err_e;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic kv, input logic [3:0] k, input logic t, input logic d,
                       input logic dr, input logic [15:0] b, input logic ln, input logic e,
                       input logic r, input logic er);
        vec_t v;
        v.kv = kv; v.key = k; v.tick = t; v.done = d; v.door = dr;
        v.bufe = b; v.loadn_e = ln; v.en_e = e; v.run_e = r; v.err_e = er;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic kv, input logic [3:0] k, input logic t, input logic d,
                         input logic dr);
        bus.key_valid = kv;
        bus.key       = k;
        bus.tick      = t;
        bus.done      = d;
        bus.door_open = dr;
    endtask

    task automatic check(input string name, input logic [15:0] b, input logic ln,
                         input logic e, input logic r, input logic er);
        logic [19:0] act, exp;
        act = {bus.data_m1, bus.data_m0, bus.data_s1, bus.data_s0,
               bus.loadn, bus.en, bus.running, bus.entry_err};
        exp = {b, ln, e, r, er};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: buf/loadn/en/running/err got %h %b%b%b%b expected %h %b%b%b%b",
                     name, act[19:4], act[3], act[2], act[1], act[0],
                     b, ln, e, r, er);
        end
    endtask

    // Reference model: buffer is the list of digits typed so far, right-aligned into MM:SS.
    localparam int M_IDLE = 0, M_ENTRY = 1, M_LOAD = 2, M_RUN = 3, M_PAUSE = 4;
    int         mode;
    logic [3:0] digs[$];
    logic       m_err;

    function automatic logic [15:0] model_buf();
        logic [15:0] v = 16'h0000;
        foreach (digs[i]) v = {v[11:0], digs[i]};
        return v;
    endfunction

    task automatic model_reset();
        mode = M_IDLE;
        digs.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] k, input logic d, input logic dr);
        logic is_dig, is_st, is_cl, nerr;
        int   sum, tens;
        is_dig = kv && (k < 4'd10);
        is_st  = kv && (k == 4'hA) && !dr;
        is_cl  = kv && (k == 4'hB);
        nerr   = 1'b0;
        case (mode)
            M_IDLE: begin
                if (is_dig) begin
                    digs.push_back(k);
                    mode = M_ENTRY;
                end else if (is_st) begin
                    digs.delete();
                    digs.push_back(4'd3);
                    digs.push_back(4'd0);
                    mode = M_LOAD;
                end
            end
            M_ENTRY: begin
                if (is_dig) begin
                    if (digs.size() == 4) nerr = 1'b1;
                    else digs.push_back(k);
                end else if (is_st) begin
                    sum = 0;
                    foreach (digs[i]) sum += int'(digs[i]);
                    tens = (digs.size() >= 2) ? int'(digs[digs.size() - 2]) : 0;
                    if (tens > 5 || sum == 0) nerr = 1'b1;
                    else mode = M_LOAD;
                end else if (is_cl) begin
                    digs.delete();
                    mode = M_IDLE;
                end
            end
            M_LOAD: mode = M_RUN;
            M_RUN: begin
                if (d) begin
                    digs.delete();
                    mode = M_IDLE;
                end else if (dr || is_cl) begin
                    mode = M_PAUSE;
                end
            end
            default: begin
                if (is_st) begin
                    mode = M_RUN;
                end else if (is_cl) begin
                    digs.delete();
                    mode = M_IDLE;
                end
            end
        endcase
        m_err = nerr;
    endtask

    initial begin
        logic       kv, t, d, dr;
        logic [3:0] k;
        int         r;

        // c0-c10: 1,2,3,0 START, run with ticks, START in RUN ignored, done+tick
        add(1, 4'd1, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        add(1, 4'd2, 0, 0, 0, 16'h0001, 1, 0, 0, 0);
        add(1, 4'd3, 0, 0, 0, 16'h0012, 1, 0, 0, 0);
        add(1, 4'd0, 0, 0, 0, 16'h0123, 1, 0, 0, 0);
        add(1, 4'hA, 0, 0, 0, 16'h1230, 1, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 16'h1230, 0, 1, 1, 0);
        add(0, 4'd0, 0, 0, 0, 16'h1230, 1, 0, 1, 0);
        add(0, 4'd0, 1, 0, 0, 16'h1230, 1, 1, 1, 0);
        add(1, 4'hA, 0, 0, 0, 16'h1230, 1, 0, 1, 0);
        add(0, 4'd0, 1, 1, 0, 16'h1230, 1, 0, 1, 0);
        add(0, 4'd0, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        // c11-c19: 0,0,7,0 START rejected, CLEAR
        add(1, 4'd0, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        add(1, 4'd0, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        add(1, 4'd7, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        add(1, 4'd0, 0, 0, 0, 16'h0007, 1, 0, 0, 0);
        add(1, 4'hA, 0, 0, 0, 16'h0070, 1, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 16'h0070, 1, 0, 0, 1);
        add(0, 4'd0, 0, 0, 0, 16'h0070, 1, 0, 0, 0);
        add(1, 4'hB, 0, 0, 0, 16'h0070, 1, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        // c20-c27: five digits, overflow error, CLEAR
        add(1, 4'd1, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        add(1, 4'd2, 0, 0, 0, 16'h0001, 1, 0, 0, 0);
        add(1, 4'd3, 0, 0, 0, 16'h0012, 1, 0, 0, 0);
        add(1, 4'd4, 0, 0, 0, 16'h0123, 1, 0, 0, 0);
        add(1, 4'd5, 0, 0, 0, 16'h1234, 1, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 16'h1234, 1, 0, 0, 1);
        add(1, 4'hB, 0, 0, 0, 16'h1234, 1, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        // c28-c38: quick start, door pause, resume without reload, done+tick
        add(1, 4'hA, 0, 0, 0, 16'h0000, 1, 0, 0, 0);
        add(0, 4'd0, 0, 0, 0, 16'h0030, 0, 1, 1, 0);
        add(1, 4'd5, 1, 0, 0, 16'h0030, 1, 1, 1, 0);
        add(0, 4'd0, 1, 0, 1, 16'h0030, 1, 1, 1, 0);
        add(0, 4'd0, 1, 0, 1, 16'h0030, 1, 0, 0, 0);
        add(1, 4'hA, 1, 0, 1, 16'h0030, 1, 0, 0, 0);
        add(1, 4'hE, 0, 0, 0, 16'h0030, 1, 0, 0, 0);
        add(1, 4'hA, 0, 0, 0, 16'h0030, 1, 0, 0, 0);
        add(0, 4'd0, 1, 0, 0, 16'h0030, 1, 1, 1, 0);
        add(0, 4'd0, 1, 1, 0, 16'h0030, 1, 0, 1, 0);
        add(0, 4'd0, 0, 0, 0, 16'h0000, 1, 0, 0, 0);

        drive(0, 4'd0, 0, 0, 0);
        clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", 16'h0000, 1, 0, 0, 0);
        @(posedge clk);
        #1 clr = 1'b0;

        foreach (tbl[i]) begin
            @(posedge clk);
            #1 drive(tbl[i].kv, tbl[i].key, tbl[i].tick, tbl[i].done, tbl[i].door);
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].bufe, tbl[i].loadn_e, tbl[i].en_e,
                  tbl[i].run_e, tbl[i].err_e);
        end

        // clr asserted mid-LOAD must clear outputs without a clock edge
        @(posedge clk);
        #1 drive(1, 4'hA, 0, 0, 0);
        @(posedge clk);
        #1 drive(0, 4'd0, 0, 0, 0);
        @(negedge clk);
        check("load_before_clr", 16'h0030, 0, 1, 1, 0);
        #1 clr = 1'b1;
        #1 check("async_clr", 16'h0000, 1, 0, 0, 0);
        @(posedge clk);
        #1 clr = 1'b0;

        model_reset();
        dr = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            kv = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 19);
            if (r < 10)      k = 4'(r);
            else if (r < 14) k = 4'hA;
            else if (r < 16) k = 4'hB;
            else             k = 4'(r - 4);
            t  = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) dr = ~dr;
            drive(kv, k, t, d, dr);
            @(negedge clk);
            check($sformatf("rand%0d", c), model_buf(), (mode != M_LOAD),
                  (mode == M_LOAD) || (mode == M_RUN && t && !d),
                  (mode == M_LOAD) || (mode == M_RUN), m_err);
            model_step(kv, k, d, dr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_entry.md
# timer_entry

Keypad-entry and load-control stage sitting directly upstream of the microwave timer counter chain (seconds-ones, seconds-tens mod-6, minutes-ones, minutes-tens). It accepts decoded keypad strobes and shifts digits into a 4-digit MM:SS buffer. On START it validates the entry, then drives the chain's parallel-load (`loadn`) and count-enable (`en`) inputs. It gates the 1 Hz tick into `en` while cooking and returns to idle when the chain reports zero.

## Interface
- `KEY_START`, default 4'hA, key code for START
- `KEY_CLEAR`, default 4'hB, key code for STOP/CLEAR
- `QUICK_SEC1`, default 4'd3, seconds-tens digit loaded on quick-start (0:30)
- `clk`  in  1  system clock, all state on rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `key_valid`  in  1  one-cycle strobe, `key` valid
- `key`  in  4  key code: 0–9 digit, `KEY_START`, `KEY_CLEAR`; 12–15 ignored
- `tick`  in  1  one-cycle pulse per second
- `done`  in  1  counter chain at 00:00 (AND of stage zero flags)
- `door_open`  in  1  level, door open
- `data_s0`, `data_s1`, `data_m0`, `data_m1`  out  4 each  buffer digits to the counter `data` inputs
- `loadn`  out  1  active-low parallel load to the chain
- `en`  out  1  chain enable
- `running`  out  1  high in LOAD and RUN
- `entry_err`  out  1  one-cycle error pulse

## Operation
- States: IDLE, ENTRY, LOAD, RUN, PAUSE. Reset → IDLE; buffer = 0; `loadn`=1; `en`=0; `running`=0; `entry_err`=0.
- Digit entry (IDLE/ENTRY): digit goes into s0; s0→s1→m0→m1 shift. Digit count saturates at 4. A 5th digit leaves the buffer unchanged and pulses `entry_err`. The first digit moves IDLE→ENTRY.
- START in IDLE, door closed: buffer ← {0,0,`QUICK_SEC1`,0}, → LOAD.
- START in ENTRY, door closed:
  - s1 > 5 or buffer all zero: pulse `entry_err`, stay in ENTRY, buffer kept.
  - otherwise → LOAD.
- START with `door_open`=1 is ignored in every state.
- LOAD: exactly one cycle with `loadn`=0 and `en`=1, then → RUN.
- RUN:
  - `en` = `tick` & ~`done`. `done` wins over a simultaneous `tick`, so the mod-6 stage never wraps 0→5.
  - `done`=1 → IDLE with buffer cleared.
  - `door_open`=1 or CLEAR → PAUSE. `done` takes priority over both.
- PAUSE: `en`=0. START (door closed) → RUN with no reload. CLEAR → IDLE, buffer cleared.
- CLEAR in ENTRY → IDLE, buffer cleared.
- Ignored keys:
  - digits in LOAD, RUN and PAUSE
  - all keys in LOAD
  - START in RUN
  - codes 12–15 everywhere
- `data_*` are direct register outputs, stable throughout LOAD and RUN.

## Timing
- Key strobe sampled on edge N. Buffer and state update at N; outputs reflect them in cycle N+1.
- START accepted at edge N: LOAD (`loadn`=0, `en`=1, `running`=1) during cycle N+1; RUN from N+2.
- Quick-start: buffer reads 0030 during the LOAD cycle.
- `entry_err`: high for exactly the cycle after the offending strobe.
- RUN: `en` is combinational from `tick`/`done` (same-cycle). `done` seen at edge N: `running`=0 from cycle N+1.
- `door_open` rising while in RUN: `en` forced 0 from the next cycle. A `tick` in that same cycle still passes.
- `clr` asserted mid-LOAD/RUN: outputs go to reset values immediately, without waiting for a clock edge.
- The mod-6 downstream stage updates `zero` only when `en`=1. A stale `done` from a prior run is cleared by the LOAD cycle, because a loaded value is never zero.

## Test plan
- Keys 1,2,3,0 then START:
  - buffer m1..s0 = 1,2,3,0
  - one cycle `loadn`=0 `en`=1
  - `en` pulses only with `tick` afterwards
- START with empty buffer → buffer 0,0,3,0, LOAD pulse, `running`=1. Later `done`=1 with `tick`=1 in the same cycle → `en`=0 that cycle, then IDLE, buffer 0000.
- Entry 0,0,7,0 then START → `entry_err`=1 for one cycle, no `loadn` pulse, state stays ENTRY.
- Keys 1,2,3,4,5:
  - buffer 1,2,3,4
  - `entry_err` pulse on the 5th key
  - CLEAR → buffer 0000
- RUN then `door_open`=1 → `en`=0 despite ticks; START while open ignored. Door closes, START → RUN resumes with no `loadn` pulse.
- Assert `clr` during the LOAD cycle → `loadn`=1, `en`=0, `running`=0 immediately; buffer 0000.
